// File: rtl/lsu_align_if.sv
// Pipeline-request and data-memory signals of the load/store alignment unit.
interface lsu_align_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_rd,
    input  stall, resp_valid, resp_rdata, fault, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rd,
    output stall, resp_valid, resp_rdata, fault, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: byte/half/word accesses onto a word-wide dmem,
// splitting word-crossing accesses into two cycles or faulting them.
module lsu_align #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_align_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [23:0] r_cap;

  logic [1:0]  w_off;
  logic [2:0]  w_nbytes;
  logic [3:0]  w_bmask;
  logic        w_illegal;
  logic        w_cross;
  logic [5:0]  w_sh;
  logic [31:0] w_word_a;
  logic [7:0]  w_lanes;
  logic [63:0] w_wd64;
  logic [63:0] w_rd64;
  logic [31:0] w_load_raw;
  logic [31:0] w_load_ext;
  logic [3:0]  w_mlanes;
  logic [31:0] w_mdata;
  logic [31:0] w_merged;

  assign w_off    = bus.req_addr[1:0];
  assign w_sh     = {1'b0, w_off, 3'b000};
  assign w_word_a = {bus.req_addr[31:2], 2'b00};

  always_comb begin
    w_nbytes = 3'd4;
    w_bmask  = 4'b1111;
    case (bus.req_size[1:0])
      2'b00:   begin w_nbytes = 3'd1; w_bmask = 4'b0001; end
      2'b01:   begin w_nbytes = 3'd2; w_bmask = 4'b0011; end
      default: begin w_nbytes = 3'd4; w_bmask = 4'b1111; end
    endcase
  end

  assign w_illegal = (bus.req_size inside {3'b011, 3'b110, 3'b111}) ||
                     (bus.req_we && bus.req_size[2]);
  assign w_cross   = (({1'b0, w_off} + w_nbytes) > 3'd4);

  // Byte lanes and store data laid out over the two-word window {A+4, A}.
  assign w_lanes = 8'({4'b0000, w_bmask} << w_off);
  assign w_wd64  = {32'h0, bus.req_wdata} << w_sh;

  // The capture holds bytes 1..3 of word A, so the same shift by the offset
  // extracts the load from either a single word or the reassembled pair.
  assign w_rd64     = (r_state == SECOND) ? {bus.mem_rd, r_cap, 8'h00}
                                          : {32'h0, bus.mem_rd};
  assign w_load_raw = 32'(w_rd64 >> w_sh);

  always_comb begin
    case (bus.req_size[1:0])
      2'b00:   w_load_ext = {{24{~bus.req_size[2] & w_load_raw[7]}},  w_load_raw[7:0]};
      2'b01:   w_load_ext = {{16{~bus.req_size[2] & w_load_raw[15]}}, w_load_raw[15:0]};
      default: w_load_ext = w_load_raw;
    endcase
  end

  assign w_mlanes = (r_state == SECOND) ? w_lanes[7:4] : w_lanes[3:0];
  assign w_mdata  = (r_state == SECOND) ? w_wd64[63:32] : w_wd64[31:0];

  always_comb begin
    w_merged = bus.mem_rd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_mlanes[i]) w_merged[8*i +: 8] = w_mdata[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt    = IDLE;
    bus.stall      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.fault      = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = w_word_a;
    bus.mem_wd     = w_merged;
    if (!rst && bus.req_valid) begin
      if (r_state == SECOND) begin
        bus.mem_addr   = w_word_a + 32'd4;
        bus.mem_we     = bus.req_we;
        bus.resp_valid = 1'b1;
        if (!bus.req_we) bus.resp_rdata = w_load_ext;
      end else if (w_illegal || (w_cross && !MISALIGN_EN)) begin
        bus.fault      = 1'b1;
        bus.resp_valid = 1'b1;
      end else if (w_cross) begin
        bus.stall   = 1'b1;
        bus.mem_we  = bus.req_we;
        w_state_nxt = SECOND;
      end else begin
        bus.mem_we     = bus.req_we;
        bus.resp_valid = 1'b1;
        if (!bus.req_we) bus.resp_rdata = w_load_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == SECOND && !bus.req_we) r_cap <= bus.mem_rd[31:8];
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed vector table, hand-written
// reset/abort/no-split sequences, and random traffic against a byte memory model.
module tb_lsu_align;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_align_if bus ();
  lsu_align_if bus0 ();

  lsu_align #(.MISALIGN_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  lsu_align #(.MISALIGN_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];

  assign bus.mem_rd  = mem[bus.mem_addr[9:2]];
  assign bus0.mem_rd = mem[bus0.mem_addr[9:2]];

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] NA = 32'h0000_0001;

  typedef struct {
    logic [31:0] pa0, pd0, pa1, pd1;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr, wdata;
    logic        e_fault;
    int          e_cyc;
    logic [31:0] e_rd;
    logic [31:0] ca0, cw0, ca1, cw1;
  } vec_t;

  vec_t tbl [14];

  logic        s_stall, s_rv, s_fault, s_we;
  logic [31:0] s_addr, s_wd, s_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    s_stall = bus.stall;
    s_rv    = bus.resp_valid;
    s_fault = bus.fault;
    s_we    = bus.mem_we;
    s_addr  = bus.mem_addr;
    s_wd    = bus.mem_wd;
    s_rd    = bus.resp_rdata;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (s_we) mem[s_addr[9:2]] = s_wd;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem[a[9:2]] = d;
    for (int i = 0; i < 4; i++) ref_mem[{a[9:2], 2'b00} + 10'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  function automatic int ref_n(input logic [2:0] s);
    if (s == 3'b000 || s == 3'b100) return 1;
    if (s == 3'b001 || s == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit ref_illegal(input logic we, input logic [2:0] s);
    return (s == 3'b011) || (s == 3'b110) || (s == 3'b111) || (we && s >= 3'b100);
  endfunction

  function automatic bit ref_cross(input logic [31:0] a, input logic [2:0] s);
    return (int'(a % 4) + ref_n(s)) > 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] v;
    logic [31:0] ba;
    v = '0;
    for (int i = 0; i < ref_n(s); i++) begin
      ba = a + 32'(i);
      v  = v | (32'(ref_mem[ba[9:0]]) << (8 * i));
    end
    if (s == 3'b000 && v >= 32'h80)   v = v - 32'h100;
    if (s == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    logic [31:0] ba;
    for (int i = 0; i < ref_n(s); i++) begin
      ba = a + 32'(i);
      ref_mem[ba[9:0]] = d[8*i +: 8];
    end
  endtask

  task automatic mem_check(input string nm);
    int bad;
    logic [31:0] w;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      if (mem[i] !== w) bad++;
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  task automatic idle_check();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_size  = 3'($urandom_range(0, 7));
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    sample();
    chk("idle_outputs", {27'h0, s_stall, s_rv, s_fault, s_we, |s_rd}, 32'h0);
    commit();
  endtask

  task automatic run_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic e_fault, input int e_cyc,
                         input logic [31:0] e_rd);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    sample();
    if (e_fault) begin
      chk("fault_flag", {28'h0, s_fault, s_rv, s_stall, s_we}, 32'b1100);
      chk("fault_rdata", s_rd, 32'h0);
      commit();
    end else if (e_cyc == 1) begin
      chk("single_flags", {28'h0, s_fault, s_rv, s_stall, s_we}, {28'h0, 3'b010, we});
      chk("single_addr", s_addr, a);
      if (!we) chk("single_rdata", s_rd, e_rd);
      commit();
    end else begin
      chk("split1_flags", {28'h0, s_fault, s_rv, s_stall, s_we}, {28'h0, 3'b001, we});
      chk("split1_addr", s_addr, a);
      commit();
      sample();
      chk("split2_flags", {28'h0, s_fault, s_rv, s_stall, s_we}, {28'h0, 3'b010, we});
      chk("split2_addr", s_addr, a + 32'd4);
      if (!we) chk("split2_rdata", s_rd, e_rd);
      commit();
    end
    bus.req_valid = 1'b0;
    if (!e_fault && we) ref_store(addr, size, wdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  sizes [8];
    logic [2:0]  sz;
    logic [31:0] ad, wd;
    logic        we;
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom());

    tbl[0]  = '{32'h100, 32'h11223344, NA, 0, 1'b1, 3'b000, 32'h102, 32'hAB, 1'b0, 1, 0,
                32'h100, 32'h11AB3344, NA, 0};
    tbl[1]  = '{32'h100, 32'h8000FFFF, NA, 0, 1'b0, 3'b001, 32'h102, 0, 1'b0, 1, 32'hFFFF8000,
                32'h100, 32'h8000FFFF, NA, 0};
    tbl[2]  = '{NA, 0, NA, 0, 1'b0, 3'b101, 32'h102, 0, 1'b0, 1, 32'h00008000, NA, 0, NA, 0};
    tbl[3]  = '{32'h100, 32'hDDCCBBAA, 32'h104, 32'h44332211, 1'b0, 3'b010, 32'h103, 0, 1'b0, 2,
                32'h332211DD, NA, 0, NA, 0};
    tbl[4]  = '{32'h104, 32'h44332211, 32'h108, 32'h88776655, 1'b1, 3'b001, 32'h107, 32'hBEEF,
                1'b0, 2, 0, 32'h104, 32'hEF332211, 32'h108, 32'h887766BE};
    tbl[5]  = '{NA, 0, NA, 0, 1'b0, 3'b011, 32'h100, 0, 1'b1, 1, 0, 32'h100, 32'hDDCCBBAA, NA, 0};
    tbl[6]  = '{NA, 0, NA, 0, 1'b1, 3'b011, 32'h100, 32'h12345678, 1'b1, 1, 0,
                32'h100, 32'hDDCCBBAA, NA, 0};
    tbl[7]  = '{NA, 0, NA, 0, 1'b1, 3'b100, 32'h101, 32'hFF, 1'b1, 1, 0,
                32'h100, 32'hDDCCBBAA, NA, 0};
    tbl[8]  = '{NA, 0, NA, 0, 1'b0, 3'b000, 32'h103, 0, 1'b0, 1, 32'hFFFFFFDD, NA, 0, NA, 0};
    tbl[9]  = '{NA, 0, NA, 0, 1'b0, 3'b100, 32'h103, 0, 1'b0, 1, 32'h000000DD, NA, 0, NA, 0};
    tbl[10] = '{NA, 0, NA, 0, 1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 1'b0, 1, 0,
                32'h10C, 32'hCAFEF00D, NA, 0};
    tbl[11] = '{32'hFFFFFFFC, 32'h04030201, 32'h0, 32'h08070605, 1'b0, 3'b010, 32'hFFFFFFFE, 0,
                1'b0, 2, 32'h06050403, NA, 0, NA, 0};
    tbl[12] = '{32'h200, 32'hAAAAAAAA, 32'h204, 32'hBBBBBBBB, 1'b1, 3'b010, 32'h201, 32'h44332211,
                1'b0, 2, 0, 32'h200, 32'h332211AA, 32'h204, 32'hBBBBBB44};
    tbl[13] = '{NA, 0, NA, 0, 1'b0, 3'b001, 32'h203, 0, 1'b0, 2, 32'h00004433, NA, 0, NA, 0};

    // Reset with a crossing store presented: everything must stay quiet.
    rst = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 3'b010;
    bus.req_addr   = 32'h103;
    bus.req_wdata  = 32'h12345678;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_size  = 3'b010;
    bus0.req_addr  = 32'h0;
    bus0.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("reset_outputs", {27'h0, s_stall, s_rv, s_fault, s_we, |s_rd}, 32'h0);
    commit();
    rst = 1'b0;
    idle_check();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].pa0 != NA) preload(tbl[i].pa0, tbl[i].pd0);
      if (tbl[i].pa1 != NA) preload(tbl[i].pa1, tbl[i].pd1);
      run_req(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].e_fault,
              tbl[i].e_cyc, tbl[i].e_rd);
      if (tbl[i].ca0 != NA) chk("vec_mem0", mem_word(tbl[i].ca0), tbl[i].cw0);
      if (tbl[i].ca1 != NA) chk("vec_mem1", mem_word(tbl[i].ca1), tbl[i].cw1);
    end
    mem_check("mem_after_table");

    // Split disabled: a crossing load faults at once.
    bus0.req_valid = 1'b1;
    bus0.req_addr  = 32'h101;
    @(negedge clk);
    chk("nosplit_flags", {28'h0, bus0.fault, bus0.resp_valid, bus0.stall, bus0.mem_we}, 32'b1100);
    chk("nosplit_rdata", bus0.resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    bus0.req_addr = 32'h100;
    @(negedge clk);
    chk("nosplit_aligned", bus0.resp_rdata, ref_load(32'h100, 3'b010));
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;

    // Request withdrawn in the second cycle: word A keeps its write, no response.
    preload(32'h300, 32'h03020100);
    preload(32'h304, 32'h07060504);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 3'b010;
    bus.req_addr  = 32'h302;
    bus.req_wdata = 32'h11223344;
    sample();
    chk("abort_first_stall", {31'h0, s_stall}, 32'h1);
    commit();
    ref_store(32'h302, 3'b001, 32'h3344);
    bus.req_valid = 1'b0;
    sample();
    chk("abort_outputs", {27'h0, s_stall, s_rv, s_fault, s_we, |s_rd}, 32'h0);
    commit();
    run_req(1'b0, 3'b010, 32'h300, 0, 1'b0, 1, ref_load(32'h300, 3'b010));
    chk("abort_wordA", mem_word(32'h300), 32'h33440100);
    chk("abort_wordB", mem_word(32'h304), 32'h07060504);

    // Reset during the second cycle of a crossing store.
    preload(32'h0FC, 32'h55667788);
    preload(32'h100, 32'h99AABBCC);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 3'b010;
    bus.req_addr  = 32'h0FE;
    bus.req_wdata = 32'hCAFEBABE;
    sample();
    chk("rst2_first", {29'h0, s_stall, s_we, s_rv}, 32'b110);
    chk("rst2_first_addr", s_addr, 32'h0FC);
    commit();
    ref_store(32'h0FE, 3'b001, 32'hBABE);
    rst = 1'b1;
    sample();
    chk("rst2_outputs", {27'h0, s_stall, s_rv, s_fault, s_we, |s_rd}, 32'h0);
    commit();
    rst = 1'b0;
    idle_check();
    chk("rst2_word_fc", mem_word(32'h0FC), 32'hBABE7788);
    chk("rst2_word_100", mem_word(32'h100), 32'h99AABBCC);
    run_req(1'b0, 3'b010, 32'h100, 0, 1'b0, 1, 32'h99AABBCC);

    for (int i = 0; i < 300; i++) begin
      sz = sizes[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) sz = 3'b010;
      we = 1'($urandom_range(0, 1));
      ad = $urandom();
      if ($urandom_range(0, 3) != 0) ad = ad % 1024;
      wd = $urandom();
      run_req(we, sz, ad, wd, ref_illegal(we, sz), ref_cross(ad, sz) ? 2 : 1, ref_load(ad, sz));
      if ($urandom_range(0, 3) == 0) idle_check();
    end
    mem_check("mem_after_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 SHALL have parameter MISALIGN_EN, default 1: 1 = split word-crossing accesses into two word cycles; 0 = fault them.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-005 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_size  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-009 SHALL have port stall  output  1  pipeline must hold the request unchanged next cycle.
REQ-010 SHALL have port resp_valid  output  1  access completes this cycle.
REQ-011 SHALL have port resp_rdata  output  32  extended load result.
REQ-012 SHALL have port fault  output  1  illegal or disallowed misaligned access.
REQ-013 SHALL have port mem_we  output  1  dmem write enable.
REQ-014 SHALL have port mem_addr  output  32  dmem word address, bits [1:0] always 00.
REQ-015 SHALL have port mem_wd  output  32  full merged word to write.
REQ-016 SHALL have port mem_rd  input  32  dmem combinational read of mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE and SECOND; reset state IDLE.
REQ-018 SHALL classify each access: off = addr[1:0], n = 1/2/4 bytes; crossing = off + n > 4.
REQ-019 SHALL flag illegal when req_size is 011, 110 or 111, or when req_we=1 and req_size[2]=1.
REQ-020 SHALL, for an aligned (non-crossing) legal access in IDLE, complete in the same cycle: mem_addr = {addr[31:2],00}, resp_valid=1, stall=0.
REQ-021 SHALL perform sub-word stores as single-cycle read-merge-write: mem_wd = mem_rd with only the target bytes replaced by req_wdata low bytes; mem_we=1.
REQ-022 SHALL produce load data as target bytes shifted to bit 0, sign-extended for B/H and zero-extended for BU/HU.
REQ-023 SHALL, for a crossing legal access in IDLE with MISALIGN_EN=1, assert stall=1 and resp_valid=0, access word A = {addr[31:2],00}, and go to SECOND.
REQ-024 SHALL, in that first cycle, capture the low-word bytes from mem_rd into an internal 24-bit register on a load, or write merged word A on a store.
REQ-025 SHALL, in SECOND, access word A+4 with wrap modulo 2^32, then assert stall=0 and resp_valid=1 and return to IDLE.
REQ-026 SHALL, in SECOND, combine the captured bytes with mem_rd for a load, or write merged word A+4 containing the remaining store bytes.
REQ-027 SHALL, for an illegal access, or a crossing access with MISALIGN_EN=0, assert fault=1 and resp_valid=1 for one cycle, with mem_we=0, stall=0, and resp_rdata=0.
REQ-028 SHALL drive mem_we=0, stall=0, resp_valid=0, fault=0 and resp_rdata=0 when req_valid=0.
REQ-029 SHALL, if req_valid drops while in SECOND, abort to IDLE with mem_we=0 and resp_valid=0; word A stays written.
REQ-030 SHALL generate all outputs combinationally from state, request and mem_rd, so load-to-response latency is 0 cycles aligned and 1 extra cycle crossing.

Reset
REQ-031 SHALL, while rst=1, force state IDLE, clear the capture register, and drive mem_we=0, stall=0, resp_valid=0, fault=0, resp_rdata=0.
REQ-032 SHALL, on reset in SECOND, abandon the second access; the word A store is not rolled back.

Verification
REQ-033 SHALL verify SB: mem[0x100]=0x11223344, store 0xAB to 0x102 -> one cycle, mem[0x100]=0x11AB3344, stall=0.
REQ-034 SHALL verify LH: mem[0x100]=0x8000FFFF, LH 0x102 -> 0xFFFF8000; LHU 0x102 -> 0x00008000.
REQ-035 SHALL verify crossing LW: mem[0x100]=0xDDCCBBAA, mem[0x104]=0x44332211, LW 0x103 -> cycle 1 stall=1, cycle 2 resp_rdata=0x332211DD.
REQ-036 SHALL verify crossing SH: 0xBEEF to 0x107 -> mem[0x104] byte3=0xEF, mem[0x108] byte0=0xBE, other bytes unchanged.
REQ-037 SHALL verify faults: size 011 -> fault=1, no write; MISALIGN_EN=0 with LW 0x101 -> fault=1, no stall.
REQ-038 SHALL verify reset: rst=1 in SECOND of crossing SW 0x0FE -> next cycle IDLE, only the word at 0x0FC modified, all outputs 0.
